// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue; optional same-cycle bypass under FDQ_BYPASS_EN
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [INSTR_W-1:0]       enq_instr,
  output logic                     enq_ready,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [PC_W-1:0]          deq_pc,
  output logic [INSTR_W-1:0]       deq_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
  localparam logic [INSTR_W-1:0] NOP      = INSTR_W'(32'h0000_0013);

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               bypass;
  logic               enq_fire;
  logic               deq_fire;
  logic               stored_valid;

  assign full         = (cnt == FULL_CNT);
  assign empty        = (cnt == '0);
  assign count        = cnt;
  assign enq_ready    = !full;
  assign stored_valid = !empty;

`ifdef FDQ_BYPASS_EN
  assign bypass = empty && enq_valid && deq_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Bypassed entries go straight to decode and never touch storage.
  assign enq_fire = enq_valid && enq_ready && !flush && !bypass;
  assign deq_fire = stored_valid && deq_ready && !flush;

  // Head presentation: stored head when occupied, bypass data when forwarding, idle values otherwise.
  always_comb begin
    deq_valid = stored_valid;
    deq_pc    = '0;
    deq_instr = NOP;
    if (stored_valid) begin
      deq_pc    = mem_pc[rd_ptr];
      deq_instr = mem_instr[rd_ptr];
    end else if (bypass) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end
  end

  // Storage is written only on an accepted enqueue and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_pc[wr_ptr]    <= enq_pc;
      mem_instr[wr_ptr] <= enq_instr;
    end
  end

  // Pointer and occupancy state; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - randomized bench for fetch_decode_queue against a queue-based model
module tb_fetch_decode_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               enq_valid = 1'b0;
  logic [PC_W-1:0]    enq_pc = '0;
  logic [INSTR_W-1:0] enq_instr = '0;
  logic               enq_ready;
  logic               deq_ready = 1'b0;
  logic               deq_valid;
  logic [PC_W-1:0]    deq_pc;
  logic [INSTR_W-1:0] deq_instr;
  logic [2:0]         count;
  logic               full;
  logic               empty;

  int tests  = 0;
  int errors = 0;

  logic [63:0] model_q[$];
  logic [31:0] next_pc = 32'h100;

  fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_ready(enq_ready),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs derived from the model queue and the inputs currently driven.
  task automatic check_outputs(input string ctx);
    int n;
    logic bp;
    logic exp_v;
    logic [31:0] exp_pc, exp_in;
    n  = model_q.size();
    bp = 1'b0;
`ifdef FDQ_BYPASS_EN
    bp = (n == 0) && enq_valid && deq_ready && !flush;
`endif
    exp_v  = (n > 0) || bp;
    exp_pc = 32'h0;
    exp_in = 32'h13;
    if (n > 0) begin
      exp_pc = model_q[0][63:32];
      exp_in = model_q[0][31:0];
    end else if (bp) begin
      exp_pc = enq_pc;
      exp_in = enq_instr;
    end
    check({ctx, ".count"},     64'(count),     64'(n));
    check({ctx, ".full"},      64'(full),      64'(n == DEPTH));
    check({ctx, ".empty"},     64'(empty),     64'(n == 0));
    check({ctx, ".enq_ready"}, 64'(enq_ready), 64'(n < DEPTH));
    check({ctx, ".deq_valid"}, 64'(deq_valid), 64'(exp_v));
    check({ctx, ".deq_pc"},    64'(deq_pc),    64'(exp_pc));
    check({ctx, ".deq_instr"}, 64'(deq_instr), 64'(exp_in));
  endtask

  // One clock of stimulus: drive after the falling edge, check, then advance the model.
  task automatic step(input string ctx, input logic ev, input logic [31:0] pc,
                      input logic [31:0] ins, input logic dr, input logic fl);
    int n;
    logic bp;
    @(negedge clk);
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    deq_ready = dr;
    flush     = fl;
    #1;
    check_outputs(ctx);
    n  = model_q.size();
    bp = 1'b0;
`ifdef FDQ_BYPASS_EN
    bp = (n == 0) && ev && dr && !fl;
`endif
    if (fl) begin
      model_q.delete();
    end else if (!bp) begin
      if (n > 0 && dr) void'(model_q.pop_front());
      if (ev && n < DEPTH) model_q.push_back({pc, ins});
    end
  endtask

  task automatic push(input string ctx, input logic dr);
    step(ctx, 1'b1, next_pc, $urandom, dr, 1'b0);
    next_pc += 4;
  endtask

  task automatic idle(input string ctx, input logic dr);
    step(ctx, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, dr, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    check_outputs("reset");
    check("reset.instr_nop", 64'(deq_instr), 64'h13);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset.enq_ready", 64'(enq_ready), 64'h1);

    // Fill with deq_ready low, 5th push ignored, then drain in order
    step("fill0", 1'b1, 32'h0, 32'hA0, 1'b0, 1'b0);
    step("fill1", 1'b1, 32'h4, 32'hA1, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h8, 32'hA2, 1'b0, 1'b0);
    step("fill3", 1'b1, 32'hC, 32'hA3, 1'b0, 1'b0);
    step("fill4", 1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    check("fill.full_flag", 64'(full), 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      #1;
      check("drain.order", 64'(deq_pc), 64'(i * 4));
      void'(model_q.pop_front());
    end
    idle("drained", 1'b0);

    // Simultaneous enq/deq at count 2 across pointer wrap
    push("sim_pre", 1'b0);
    push("sim_pre", 1'b0);
    for (int i = 0; i < 6; i++) push("sim", 1'b1);
    idle("sim_post", 1'b0);
    check("sim.count2", 64'(count), 64'h2);

    // Full plus dequeue: enqueue blocked this cycle, accepted next
    push("fd_pre", 1'b0);
    push("fd_pre", 1'b0);
    push("fd_full", 1'b1);
    push("fd_next", 1'b0);
    idle("fd_post", 1'b0);
    check("fd.count4", 64'(count), 64'h4);

    // Flush at count 3 with same-cycle enq and deq; flushed pc must never appear
    idle("fl_pre", 1'b1);
    step("flush", 1'b1, 32'hDEAD_0000, 32'h1, 1'b1, 1'b1);
    idle("fl_post", 1'b1);
    idle("fl_post2", 1'b1);

    // Bypass scenario; the model reflects whichever build is in use
    step("bypass", 1'b1, 32'h40, 32'h0050_0093, 1'b1, 1'b0);
    idle("bypass_next", 1'b1);
    idle("bypass_after", 1'b1);

    // Asynchronous reset mid-traffic with three entries held
    push("rst_pre", 1'b0);
    push("rst_pre", 1'b0);
    push("rst_pre", 1'b0);
    @(negedge clk);
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    flush     = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst.count", 64'(count), 64'h0);
    check("arst.empty", 64'(empty), 64'h1);
    check("arst.deq_valid", 64'(deq_valid), 64'h0);
    check("arst.deq_instr", 64'(deq_instr), 64'h13);
    model_q.delete();
    enq_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst.enq_ready", 64'(enq_ready), 64'h1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic ev, dr, fl;
      ev = ($urandom_range(0, 9) < 6);
      dr = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 15) == 0);
      step("rand", ev, next_pc, $urandom, dr, fl);
      next_pc += 4;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
